// File: rtl/hb_pkg.sv
// hb_pkg: default halfband coefficients, NTAPS legality check and round/saturate helper
package hb_pkg;
  localparam int HB27_NPAIR = 7;
  localparam logic signed [15:0] HB27_PAIRS [HB27_NPAIR] = '{
    16'sd2, -16'sd20, 16'sd101, -16'sd361, 16'sd1032, -16'sd2710, 16'sd10148
  };
  localparam logic signed [15:0] HB27_CENTRE = 16'sd16384;

  // Halfband structure needs NTAPS = 4K+3 so that the centre tap lands on an odd index.
  function automatic bit ntaps_ok(input int n);
    return n >= 7 && (n - 3) % 4 == 0;
  endfunction

  // Reset value of coefficient slot idx; slot NPAIR is the centre tap.
  function automatic logic signed [31:0] coef_default(input int ntaps, input int idx, input int coef_w);
    if (idx == (ntaps + 1) / 4)
      return ntaps == 27 ? 32'(HB27_CENTRE) : 32'sd1 <<< (coef_w - 2);
    return ntaps == 27 && idx < HB27_NPAIR ? 32'(HB27_PAIRS[idx]) : 32'sd0;
  endfunction

  // Round half up from Q(coef_w-1) and clamp to a data_w-bit signed range.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc, input int coef_w, input int data_w);
    logic signed [63:0] r, hi, lo;
    r = (acc + (64'sd1 <<< (coef_w - 2))) >>> (coef_w - 1);
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    return r > hi ? hi : r < lo ? lo : r;
  endfunction
endpackage

// File: rtl/hb_delay_line.sv
// hb_delay_line: per-channel sample history, decimation phase bit and saturating fill count
//   clk, reset_n : clock, async active-low reset
//   clear        : synchronous zeroing of all state
//   shift, x     : accept x into the line (taps[0] is newest)
//   taps         : full history vector
//   phase, fill  : decimation phase and number of valid samples (saturates at NTAPS)
module hb_delay_line #(
  parameter int DATA_W = 16,
  parameter int NTAPS = 27,
  localparam int FW = $clog2(NTAPS + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic shift,
  input  logic [DATA_W-1:0] x,
  output logic [NTAPS-1:0][DATA_W-1:0] taps,
  output logic phase,
  output logic [FW-1:0] fill
);
  localparam logic [FW-1:0] FULL = FW'(NTAPS);

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      taps <= '0;
      phase <= 1'b0;
      fill <= '0;
    end else if (clear) begin
      taps <= '0;
      phase <= 1'b0;
      fill <= '0;
    end else if (shift) begin
      taps <= {taps[NTAPS-2:0], x};
      phase <= ~phase;
      fill <= fill == FULL ? fill : fill + 1'b1;
    end
endmodule

// File: rtl/hb_decim_mc.sv
// hb_decim_mc: multi-channel halfband decimate-by-2 FIR with shared pipelined symmetric MAC
//   clk, reset_n          : clock, async active-low reset
//   clear, bypass         : sync datapath clear; pass-through mode (sampled with the sample)
//   x_in/_ch/_valid       : channel-tagged input samples, one per clock
//   coef_we/_addr/_wdata  : coefficient file write (addr NPAIR is the centre tap)
//   y_out/_ch/_valid      : filtered output, 4 clocks after the accepting edge
module hb_decim_mc
  import hb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int NTAPS = 27,
  parameter int NCH = 2,
  localparam int CH_W = NCH > 1 ? $clog2(NCH) : 1,
  localparam int NPAIR = (NTAPS + 1) / 4,
  localparam int AW = $clog2(NPAIR + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic bypass,
  input  logic [DATA_W-1:0] x_in,
  input  logic [CH_W-1:0] x_in_ch,
  input  logic x_in_valid,
  input  logic coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [COEF_W-1:0] coef_wdata,
  output logic [DATA_W-1:0] y_out,
  output logic [CH_W-1:0] y_out_ch,
  output logic y_out_valid
);
  localparam int C = (NTAPS - 1) / 2;
  localparam int FW = $clog2(NTAPS + 1);
  localparam int SW = DATA_W + COEF_W + $clog2(NPAIR + 1) + 1;
  localparam logic [FW-1:0] LAST = FW'(NTAPS - 1);
  localparam logic [AW-1:0] CMAX = AW'(NPAIR);

  if (!ntaps_ok(NTAPS)) begin : g_bad
    $error("hb_decim_mc: NTAPS must be 4K+3 with K>=1");
  end

  logic [NTAPS-1:0][DATA_W-1:0] taps [NCH];
  logic phase [NCH];
  logic [FW-1:0] fill [NCH];
  logic accept, emit;
  logic [3:0] v;
  logic [3:0][CH_W-1:0] chp;
  logic [3:0] bp;
  logic [3:0][DATA_W-1:0] xp;
  logic [NTAPS-1:0][DATA_W-1:0] tsel;
  logic signed [COEF_W-1:0] coef [NPAIR+1];
  logic signed [DATA_W:0] pair1 [NPAIR];
  logic signed [DATA_W-1:0] ctr1;
  logic signed [SW-1:0] prod2 [NPAIR+1];
  logic signed [SW-1:0] acc3, sum;
  logic [DATA_W-1:0] y_sat;

  assign accept = x_in_valid && !clear && 32'(x_in_ch) < NCH;
  // An output is due on the even sample that completes (or follows) a full line.
  assign emit = accept && (bypass || (phase[x_in_ch] && fill[x_in_ch] >= LAST));

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    hb_delay_line #(.DATA_W(DATA_W), .NTAPS(NTAPS)) u_dl (
      .clk(clk),
      .reset_n(reset_n),
      .clear(clear),
      .shift(accept && x_in_ch == CH_W'(c)),
      .x(x_in),
      .taps(taps[c]),
      .phase(phase[c]),
      .fill(fill[c])
    );
  end

  // Pair stage reads the line one edge after the accept, so it sees the just-shifted history.
  assign tsel = taps[chp[0]];

  always_comb begin
    sum = '0;
    for (int i = 0; i <= NPAIR; i++) sum = sum + prod2[i];
  end

  assign y_sat = DATA_W'(round_sat(64'(acc3), COEF_W, DATA_W));

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)
      for (int i = 0; i <= NPAIR; i++) coef[i] <= COEF_W'(coef_default(NTAPS, i, COEF_W));
    else if (coef_we && coef_addr <= CMAX)
      coef[coef_addr] <= coef_wdata;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      v <= '0;
      chp <= '0;
      bp <= '0;
      xp <= '0;
      ctr1 <= '0;
      acc3 <= '0;
      y_out <= '0;
      y_out_ch <= '0;
      y_out_valid <= 1'b0;
      for (int i = 0; i < NPAIR; i++) pair1[i] <= '0;
      for (int i = 0; i <= NPAIR; i++) prod2[i] <= '0;
    end else begin
      v <= clear ? '0 : {v[2:0], emit};
      chp <= {chp[2:0], x_in_ch};
      bp <= {bp[2:0], bypass};
      xp <= {xp[2:0], x_in};
      for (int i = 0; i < NPAIR; i++)
        pair1[i] <= {tsel[2*i][DATA_W-1], tsel[2*i]} + {tsel[NTAPS-1-2*i][DATA_W-1], tsel[NTAPS-1-2*i]};
      ctr1 <= tsel[C];
      for (int i = 0; i < NPAIR; i++) prod2[i] <= SW'(pair1[i]) * SW'(coef[i]);
      prod2[NPAIR] <= SW'(ctr1) * SW'(coef[NPAIR]);
      acc3 <= sum;
      y_out_valid <= v[3];
      if (v[3]) begin
        y_out <= bp[3] ? xp[3] : y_sat;
        y_out_ch <= chp[3];
      end
    end
endmodule

// File: tb/tb_hb_decim_mc.sv
// tb_hb_decim_mc: directed + randomized bench against a direct-convolution reference model
module tb_hb_decim_mc;
  localparam int DATA_W = 16, COEF_W = 16, NTAPS = 27, NCH = 2;
  localparam int NPAIR = (NTAPS + 1) / 4, C = (NTAPS - 1) / 2, AW = 3, CH_W = 1;
  localparam int YMAX = (1 << (DATA_W - 1)) - 1, YMIN = -(1 << (DATA_W - 1));

  logic clk = 1'b0, reset_n = 1'b0, clear = 1'b0, bypass = 1'b0, x_in_valid = 1'b0, coef_we = 1'b0;
  logic [DATA_W-1:0] x_in = '0;
  logic [CH_W-1:0] x_in_ch = '0;
  logic [AW-1:0] coef_addr = '0;
  logic [COEF_W-1:0] coef_wdata = '0;
  logic [DATA_W-1:0] y_out;
  logic [CH_W-1:0] y_out_ch;
  logic y_out_valid;

  always #5 clk = ~clk;

  hb_decim_mc #(.DATA_W(DATA_W), .COEF_W(COEF_W), .NTAPS(NTAPS), .NCH(NCH)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .bypass(bypass),
    .x_in(x_in), .x_in_ch(x_in_ch), .x_in_valid(x_in_valid),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .y_out(y_out), .y_out_ch(y_out_ch), .y_out_valid(y_out_valid)
  );

  typedef struct { int cyc; int y; int ch; } exp_t;
  exp_t q[$];
  int hist [NCH][NTAPS];
  int ph [NCH];
  int fl [NCH];
  int cm [NPAIR+1];
  int dflt [NPAIR+1] = '{2, -20, 101, -361, 1032, -2710, 10148, 16384};
  int obs_cnt [NCH];
  int cyc = 0, errors = 0, checks = 0, last_y = 0, last_ch = 0;

  function automatic int h(int k);
    if (k == C) return cm[NPAIR];
    if (k % 2 != 0) return 0;
    return cm[(k < C ? k : NTAPS - 1 - k) / 2];
  endfunction

  function automatic int filt(int c);
    longint acc = 0;
    for (int k = 0; k < NTAPS; k++) acc += longint'(h(k)) * longint'(hist[c][k]);
    acc = (acc + (longint'(1) << (COEF_W - 2))) >>> (COEF_W - 1);
    return acc > YMAX ? YMAX : acc < YMIN ? YMIN : int'(acc);
  endfunction

  function automatic int rnd();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  task automatic chk(string tag, logic signed [63:0] got, logic signed [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_zero();
    for (int c = 0; c < NCH; c++) begin
      ph[c] = 0;
      fl[c] = 0;
      for (int k = 0; k < NTAPS; k++) hist[c][k] = 0;
    end
  endtask

  task automatic step(input logic v, input int ch, input int x, input logic byp, input logic clr,
                      input logic we, input int addr, input int wd);
    exp_t e;
    bit emit;
    @(negedge clk);
    x_in_valid = v; x_in_ch = CH_W'(ch); x_in = DATA_W'(x); bypass = byp; clear = clr;
    coef_we = we; coef_addr = AW'(addr); coef_wdata = COEF_W'(wd);
    @(posedge clk);
    cyc++;
    if (clr) begin
      q = q.find with (item.cyc <= cyc);
      model_zero();
    end
    if (we && addr <= NPAIR) cm[addr] = wd;
    if (v && !clr && ch < NCH) begin
      for (int k = NTAPS - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
      hist[ch][0] = x;
      emit = byp || (ph[ch] == 1 && fl[ch] >= NTAPS - 1);
      ph[ch] ^= 1;
      fl[ch] = fl[ch] < NTAPS ? fl[ch] + 1 : NTAPS;
      if (emit) begin
        e.cyc = cyc + 4; e.y = byp ? x : filt(ch); e.ch = ch;
        q.push_back(e);
      end
    end
    #1;
    if (y_out_valid === 1'b1) obs_cnt[y_out_ch]++;
    if (q.size() > 0 && q[0].cyc == cyc) begin
      chk("valid", y_out_valid, 1);
      chk("y", $signed(y_out), q[0].y);
      chk("ch", y_out_ch, q[0].ch);
      last_y = q[0].y; last_ch = q[0].ch;
      void'(q.pop_front());
    end else begin
      chk("idle_valid", y_out_valid, 0);
      chk("hold_y", $signed(y_out), last_y);
      chk("hold_ch", y_out_ch, last_ch);
    end
  endtask

  task automatic smp(input int ch, input int x);
    step(1'b1, ch, x, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic clr();
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0, 0);
    for (int c = 0; c < NCH; c++) obs_cnt[c] = 0;
  endtask

  task automatic wcoef(input int addr, input int wd);
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, addr, wd);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    x_in_valid = 1'b0; clear = 1'b0; bypass = 1'b0; coef_we = 1'b0;
    #1;
    q.delete();
    model_zero();
    cm = dflt;
    last_y = 0; last_ch = 0;
    for (int c = 0; c < NCH; c++) obs_cnt[c] = 0;
    chk("rst_valid", y_out_valid, 0);
    chk("rst_y", $signed(y_out), 0);
    chk("rst_ch", y_out_ch, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    model_zero();
    cm = dflt;
    do_reset();

    // impulse: lands on tap 26 at sample 28, then a second impulse sweeps every even tap
    for (int n = 1; n <= 28; n++) smp(0, n == 2 ? 32767 : 0);
    repeat (4) idle();
    chk("imp28_valid", y_out_valid, 1);
    chk("imp28_y", $signed(y_out), 2);
    for (int n = 29; n <= 80; n++) smp(0, n == 40 ? 32767 : 0);
    repeat (4) idle();

    // DC saturation with oversized coefficients
    clr();
    for (int i = 0; i < NPAIR; i++) wcoef(i, 16384);
    wcoef(NPAIR, 32767);
    for (int n = 0; n < 40; n++) smp(0, 32767);
    repeat (4) idle();
    chk("dc_pos", $signed(y_out), 32767);
    clr();
    for (int n = 0; n < 40; n++) smp(0, -32768);
    repeat (4) idle();
    chk("dc_neg", $signed(y_out), -32768);
    for (int i = 0; i <= NPAIR; i++) wcoef(i, dflt[i]);

    // interleaved channels
    clr();
    for (int n = 0; n < 80; n++) smp(n % 2, n % 2 ? -1000 : 1000);
    repeat (4) idle();
    chk("il_cnt0", obs_cnt[0], 7);
    chk("il_cnt1", obs_cnt[1], 7);

    // clear one cycle after an output-producing accept
    clr();
    for (int n = 0; n < 30; n++) smp(0, rnd());
    clr();
    for (int n = 0; n < 4; n++) begin
      idle();
      chk("clr_quiet", y_out_valid, 0);
    end
    for (int n = 0; n < 27; n++) smp(0, rnd());
    repeat (4) idle();
    chk("clr_cnt27", obs_cnt[0], 0);
    smp(0, rnd());
    repeat (4) idle();
    chk("clr_cnt28", obs_cnt[0], 1);

    // bypass on ch1
    clr();
    step(1'b1, 1, 5, 1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1, -7, 1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1, 32767, 1'b1, 1'b0, 1'b0, 0, 0);
    repeat (4) idle();
    chk("byp_cnt", obs_cnt[1], 3);
    chk("byp_last", $signed(y_out), 32767);

    // randomized mix of channels, bypass, gaps and occasional clears
    for (int n = 0; n < 400; n++)
      step($urandom_range(3) != 0, int'($urandom_range(1)), rnd(), $urandom_range(9) == 0,
           $urandom_range(99) == 0, 1'b0, 0, 0);
    repeat (4) idle();

    // coefficient write coincident with an output-producing sample, then reset mid-stream
    clr();
    for (int n = 0; n < 29; n++) smp(0, rnd());
    idle();
    step(1'b1, 0, 30000, 1'b0, 1'b0, 1'b1, NPAIR, 20000);
    for (int n = 0; n < 3; n++) smp(0, rnd());
    do_reset();
    for (int n = 0; n < 4; n++) begin
      idle();
      chk("post_rst_quiet", y_out_valid, 0);
    end
    for (int n = 0; n < 40; n++) smp(0, rnd());
    repeat (4) idle();
    chk("post_rst_cnt", obs_cnt[0], 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hb_decim_mc.md
# hb_decim_mc

Parametrised, multi-channel halfband decimate-by-2 FIR for the audio chain. Sits in the same slot as the existing fixed stereo halfband stage.
- Accepts channel-tagged samples one per clock.
- Keeps an independent delay line and decimation phase per channel.
- Shares one pipelined symmetric-pair MAC across channels.
- Adds round-to-nearest with saturation, runtime coefficient load, synchronous clear and a bypass mode.

## Interface
Parameters:
- DATA_W, 16: sample width, signed two's complement.
- COEF_W, 16: coefficient width, signed Q(COEF_W-1).
- NTAPS, 27: filter length; must satisfy NTAPS = 4K+3, K≥1. NPAIR = (NTAPS+1)/4 nonzero pairs; centre index C = (NTAPS-1)/2.
- NCH, 2: channels, ≥1. CH_W = max(1, $clog2(NCH)).

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear of datapath state.
- bypass  in  1  1 = pass samples through undecimated and unfiltered.
- x_in  in  DATA_W  input sample.
- x_in_ch  in  CH_W  channel of x_in.
- x_in_valid  in  1  sample strobe; no backpressure.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  $clog2(NPAIR+1)  0..NPAIR-1 = pair h[2i]; NPAIR = centre h[C].
- coef_wdata  in  COEF_W  coefficient value.
- y_out  out  DATA_W  filtered sample.
- y_out_ch  out  CH_W  channel of y_out.
- y_out_valid  out  1  one-cycle strobe per output.

## Operation
- Acceptance: sample accepted when x_in_valid=1, clear=0 and x_in_ch<NCH. Out-of-range channels are silently dropped.
- On acceptance the channel's delay line shifts in x_in, its phase bit toggles, and its fill counter increments, saturating at NTAPS.
- Filter output y[n] = Σ h[k]·x[n−k], k=0..NTAPS−1, with h[k]=h[NTAPS−1−k].
  - Odd k≠C contribute zero.
  - Implementation: pair sums (DATA_W+1 bits), NPAIR+1 products, adder tree of width DATA_W+COEF_W+$clog2(NPAIR+1)+1.
- Decimation: an output is produced only for a channel's 2nd, 4th, 6th… accepted sample (phase bit was 1 before the toggle), and only once that sample makes fill = NTAPS. With NTAPS=27, the first output is on the 28th sample.
- Scaling: add 2^(COEF_W−2), arithmetic shift right by COEF_W−1, then saturate to [−2^(DATA_W−1), 2^(DATA_W−1)−1]. No wrap.
- Bypass: sampled with the sample. Every accepted sample emits y_out = x_in unmodified with the same latency. Delay line, phase and fill still update.
- Coefficients: register file of NPAIR+1 entries, written on coef_we. The value is used by any sample reaching the product stage on the cycle after the write edge or later. There is no interlock; mid-stream writes are legal and take effect deterministically.
- clear: zeroes all delay lines, phase bits, fill counters and in-flight valids in one cycle. Coefficients are retained. x_in is ignored that cycle.
- Reset state:
  - Coefficients take hb_pkg defaults when NTAPS=27 (pairs 2, −20, 101, −361, 1032, −2710, 10148; centre 16384). Otherwise pairs are 0 and centre is 2^(COEF_W−2).
  - All other state is 0.

## Timing
- Accept edge t → delay-line update at t, pair stage at t+1, product stage at t+2, sum at t+3, round/saturate register at t+4. y_out_valid is high for exactly the cycle after edge t+4.
- Latency 4 clocks, filtered or bypass.
- Throughput 1 sample/clock in any channel mix, including back-to-back samples on the same channel.
- y_out and y_out_ch hold their last value when y_out_valid=0.
- Reset values: y_out=0, y_out_ch=0, y_out_valid=0.
- Reset mid-operation: all in-flight outputs are lost. After release, the first output per channel again requires a full NTAPS fill.
- clear at edge t kills outputs scheduled at t+1..t+4. Samples accepted at t+1 onward are processed normally.
- Simultaneous coef_we and x_in_valid: both take effect. That sample uses the new coefficient.

## Structure
- hb_pkg holds:
  - the default 27-tap coefficient constant;
  - an NTAPS legality check function (elaboration-time $error if NTAPS ≠ 4K+3);
  - a round_sat function parametrised by widths.
- Sub-module hb_delay_line: one per channel via generate. Contains the shift register, phase bit and fill counter, plus a tap-vector output.
- The top level contains a channel mux into the shared pair/product/sum pipeline, the coefficient register file and the channel-tag pipeline.

## Test plan
- Impulse: ch0 receives 32767 followed by zeros.
  - With default coefficients and no bypass, the even-index outputs reproduce h[k] scaled.
  - The sample-28 output equals round(32767·2/32768)=2; subsequent decimated outputs follow the remaining coefficients.
- DC saturation: constant 32767 on ch0, with centre rewritten to 32767 and pairs to 16384. Every output saturates at 32767. Repeat with −32768 and expect −32768.
- Interleave: ch0 constant 1000, ch1 constant −1000, alternating every cycle.
  - After fill, y_out_ch alternates 0/1.
  - Values are 1000 and −1000 within ±1, as the default coefficients sum to 1.
  - Each channel emits one output per 2 of its inputs.
- Clear: assert clear mid-stream one cycle after an accept. No y_out_valid in the next 4 cycles, and the next output requires 28 new samples.
- Bypass: bypass=1 with samples 5, −7, 32767 on ch1. Outputs are identical, 4 cycles later each, one per input.
- Coefficient write coincident with x_in_valid, then reset mid-stream: verify the new coefficient applies to that sample, and that all outputs are 0/invalid after reset with defaults restored.
